rpn_to_network_bridge_merger: RTL and testbench

Packet-level AXI-Stream arbiter that merges the four RPN sub-block egress streams (LAN, WAN, WNN, KIP) into the single stream toward the network bridge. It sits on the transmit path of the control API reliability layer, mirroring the receive-side split by message type. Whole packets are forwarded without interleaving. Arbitration is round-robin.

---
 rtl/rpn_to_network_bridge_merger.sv | 204 ++++++++++++++++++++
 tb/tb_rpn_to_network_bridge_merger.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rpn_to_network_bridge_merger.sv
// rtl/rpn_to_network_bridge_merger.sv - round-robin packet merger of the four RPN egress streams toward the network bridge
// Optional feature macro: RPN_TO_NB_MERGER_OUTPUT_REG_EN (registered 2-entry output skid buffer)
module rpn_to_network_bridge_merger #(
  parameter int AXIS_DATA_WIDTH        = 512,
  parameter int AXIS_KEEP_WIDTH        = AXIS_DATA_WIDTH/8,
  parameter int AXIS_TO_NB_TDEST_WIDTH = 16,
  parameter int AXIS_TO_NB_TUSER_WIDTH = 16
) (
  input  logic                              i_clk,
  input  logic                              i_ap_rst_n,

  input  logic                              from_rpn_LAN_tvalid,
  output logic                              from_rpn_LAN_tready,
  input  logic [AXIS_DATA_WIDTH-1:0]        from_rpn_LAN_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0]        from_rpn_LAN_tkeep,
  input  logic [AXIS_TO_NB_TDEST_WIDTH-1:0] from_rpn_LAN_tid,
  input  logic [AXIS_TO_NB_TDEST_WIDTH-1:0] from_rpn_LAN_tdest,
  input  logic [AXIS_TO_NB_TUSER_WIDTH-1:0] from_rpn_LAN_tuser,
  input  logic                              from_rpn_LAN_tlast,

  input  logic                              from_rpn_WAN_tvalid,
  output logic                              from_rpn_WAN_tready,
  input  logic [AXIS_DATA_WIDTH-1:0]        from_rpn_WAN_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0]        from_rpn_WAN_tkeep,
  input  logic [AXIS_TO_NB_TDEST_WIDTH-1:0] from_rpn_WAN_tid,
  input  logic [AXIS_TO_NB_TDEST_WIDTH-1:0] from_rpn_WAN_tdest,
  input  logic [AXIS_TO_NB_TUSER_WIDTH-1:0] from_rpn_WAN_tuser,
  input  logic                              from_rpn_WAN_tlast,

  input  logic                              from_rpn_WNN_tvalid,
  output logic                              from_rpn_WNN_tready,
  input  logic [AXIS_DATA_WIDTH-1:0]        from_rpn_WNN_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0]        from_rpn_WNN_tkeep,
  input  logic [AXIS_TO_NB_TDEST_WIDTH-1:0] from_rpn_WNN_tid,
  input  logic [AXIS_TO_NB_TDEST_WIDTH-1:0] from_rpn_WNN_tdest,
  input  logic [AXIS_TO_NB_TUSER_WIDTH-1:0] from_rpn_WNN_tuser,
  input  logic                              from_rpn_WNN_tlast,

  input  logic                              from_rpn_KIP_tvalid,
  output logic                              from_rpn_KIP_tready,
  input  logic [AXIS_DATA_WIDTH-1:0]        from_rpn_KIP_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0]        from_rpn_KIP_tkeep,
  input  logic [AXIS_TO_NB_TDEST_WIDTH-1:0] from_rpn_KIP_tid,
  input  logic [AXIS_TO_NB_TDEST_WIDTH-1:0] from_rpn_KIP_tdest,
  input  logic [AXIS_TO_NB_TUSER_WIDTH-1:0] from_rpn_KIP_tuser,
  input  logic                              from_rpn_KIP_tlast,

  output logic                              to_network_bridge_tvalid,
  input  logic                              to_network_bridge_tready,
  output logic [AXIS_DATA_WIDTH-1:0]        to_network_bridge_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0]        to_network_bridge_tkeep,
  output logic [AXIS_TO_NB_TDEST_WIDTH-1:0] to_network_bridge_tid,
  output logic [AXIS_TO_NB_TDEST_WIDTH-1:0] to_network_bridge_tdest,
  output logic [AXIS_TO_NB_TUSER_WIDTH-1:0] to_network_bridge_tuser,
  output logic                              to_network_bridge_tlast,

  output logic                              o_busy,
  output logic [1:0]                        o_grant,
  output logic [31:0]                       o_pkt_count
);

  // One beat packed as {tdata, tkeep, tid, tdest, tuser, tlast}; tlast sits in bit 0.
  localparam int BW = AXIS_DATA_WIDTH + AXIS_KEEP_WIDTH + 2*AXIS_TO_NB_TDEST_WIDTH
                    + AXIS_TO_NB_TUSER_WIDTH + 1;

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t        state;
  logic [1:0]    grant;
  logic [1:0]    last_grant;
  logic [31:0]   pkt_count;

  logic [3:0]    src_valid;
  logic [BW-1:0] src_beat [4];
  logic [3:0]    src_ready;

  logic          sel_valid;
  logic [BW-1:0] sel_beat;
  logic          sel_last;
  logic          sink_ready;
  logic          src_accept;

  logic [1:0]    rr_next;
  logic          rr_found;

  logic          out_valid;
  logic [BW-1:0] out_beat;

  assign src_valid = {from_rpn_KIP_tvalid, from_rpn_WNN_tvalid,
                      from_rpn_WAN_tvalid, from_rpn_LAN_tvalid};

  assign src_beat[0] = {from_rpn_LAN_tdata, from_rpn_LAN_tkeep, from_rpn_LAN_tid,
                        from_rpn_LAN_tdest, from_rpn_LAN_tuser, from_rpn_LAN_tlast};
  assign src_beat[1] = {from_rpn_WAN_tdata, from_rpn_WAN_tkeep, from_rpn_WAN_tid,
                        from_rpn_WAN_tdest, from_rpn_WAN_tuser, from_rpn_WAN_tlast};
  assign src_beat[2] = {from_rpn_WNN_tdata, from_rpn_WNN_tkeep, from_rpn_WNN_tid,
                        from_rpn_WNN_tdest, from_rpn_WNN_tuser, from_rpn_WNN_tlast};
  assign src_beat[3] = {from_rpn_KIP_tdata, from_rpn_KIP_tkeep, from_rpn_KIP_tid,
                        from_rpn_KIP_tdest, from_rpn_KIP_tuser, from_rpn_KIP_tlast};

  // Data only moves in BUSY, and only from the granted source.
  assign sel_valid  = (state == ST_BUSY) && src_valid[grant];
  assign sel_beat   = src_beat[grant];
  assign sel_last   = sel_beat[0];
  assign src_accept = sel_valid && sink_ready;
  assign src_ready  = ((state == ST_BUSY) && sink_ready) ? (4'b0001 << grant) : 4'b0000;

  assign from_rpn_LAN_tready = src_ready[0];
  assign from_rpn_WAN_tready = src_ready[1];
  assign from_rpn_WNN_tready = src_ready[2];
  assign from_rpn_KIP_tready = src_ready[3];

  // Round-robin search: first requester strictly after last_grant in LAN->WAN->WNN->KIP order.
  always_comb begin
    rr_next  = last_grant;
    rr_found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if (!rr_found && src_valid[2'(last_grant + 2'(i))]) begin
        rr_next  = 2'(last_grant + 2'(i));
        rr_found = 1'b1;
      end
    end
  end

  // Packet-level FSM: grant is latched in IDLE and frozen until the granted packet's tlast is taken.
  always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
    if (!i_ap_rst_n) begin
      state      <= ST_IDLE;
      grant      <= 2'd0;
      last_grant <= 2'd3;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rr_found) begin
            grant <= rr_next;
            state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (src_accept && sel_last) begin
            last_grant <= grant;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef RPN_TO_NB_MERGER_OUTPUT_REG_EN
  logic          skid_valid;
  logic [BW-1:0] skid_beat;

  // The source sees space only while the skid slot is empty, so its tready comes straight from a flop.
  assign sink_ready = !skid_valid;

  // Output register plus one skid slot: a beat accepted while the output stalls parks in the skid.
  always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
    if (!i_ap_rst_n) begin
      out_valid  <= 1'b0;
      out_beat   <= '0;
      skid_valid <= 1'b0;
      skid_beat  <= '0;
    end else if (!out_valid || to_network_bridge_tready) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_beat   <= skid_beat;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= src_accept;
        if (src_accept) begin
          out_beat <= sel_beat;
        end
      end
    end else if (src_accept) begin
      skid_valid <= 1'b1;
      skid_beat  <= sel_beat;
    end
  end
`else
  // Straight-through mux; fields read zero outside a packet.
  assign sink_ready = to_network_bridge_tready;
  assign out_valid  = sel_valid;
  assign out_beat   = (state == ST_BUSY) ? sel_beat : '0;
`endif

  assign to_network_bridge_tvalid = out_valid;
  assign {to_network_bridge_tdata, to_network_bridge_tkeep, to_network_bridge_tid,
          to_network_bridge_tdest, to_network_bridge_tuser, to_network_bridge_tlast} = out_beat;

  // Count packets as they leave toward the bridge; wraps naturally at 2^32.
  always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
    if (!i_ap_rst_n) begin
      pkt_count <= 32'd0;
    end else if (out_valid && to_network_bridge_tready && out_beat[0]) begin
      pkt_count <= pkt_count + 32'd1;
    end
  end

  assign o_busy      = (state == ST_BUSY);
  assign o_grant     = grant;
  assign o_pkt_count = pkt_count;

endmodule

// File: tb/tb_rpn_to_network_bridge_merger.sv
// tb/tb_rpn_to_network_bridge_merger.sv - scoreboard bench for the RPN to network bridge merger
`timescale 1ns/1ps
module tb_rpn_to_network_bridge_merger;

  localparam int DW = 512;
  localparam int KW = 64;
  localparam int TW = 16;
  localparam int UW = 16;
`ifdef RPN_TO_NB_MERGER_OUTPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [1:0]  src;
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          src_valid [4];
  logic          src_ready [4];
  logic [DW-1:0] src_data  [4];
  logic [KW-1:0] src_keep  [4];
  logic [TW-1:0] src_id    [4];
  logic [TW-1:0] src_dest  [4];
  logic [UW-1:0] src_user  [4];
  logic          src_last  [4];

  logic          nb_tvalid, nb_tready, nb_tlast;
  logic [DW-1:0] nb_tdata;
  logic [KW-1:0] nb_tkeep;
  logic [TW-1:0] nb_tid, nb_tdest;
  logic [UW-1:0] nb_tuser;
  logic          o_busy;
  logic [1:0]    o_grant;
  logic [31:0]   o_pkt_count;

  logic [32:0] src_q [4][$];
  exp_t        exp_q [$];
  int          hs_cyc [$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          lan_ready_cnt = 0;
  logic        toggle = 1'b0;

  rpn_to_network_bridge_merger dut (
    .i_clk(clk), .i_ap_rst_n(rst_n),
    .from_rpn_LAN_tvalid(src_valid[0]), .from_rpn_LAN_tready(src_ready[0]),
    .from_rpn_LAN_tdata(src_data[0]), .from_rpn_LAN_tkeep(src_keep[0]),
    .from_rpn_LAN_tid(src_id[0]), .from_rpn_LAN_tdest(src_dest[0]),
    .from_rpn_LAN_tuser(src_user[0]), .from_rpn_LAN_tlast(src_last[0]),
    .from_rpn_WAN_tvalid(src_valid[1]), .from_rpn_WAN_tready(src_ready[1]),
    .from_rpn_WAN_tdata(src_data[1]), .from_rpn_WAN_tkeep(src_keep[1]),
    .from_rpn_WAN_tid(src_id[1]), .from_rpn_WAN_tdest(src_dest[1]),
    .from_rpn_WAN_tuser(src_user[1]), .from_rpn_WAN_tlast(src_last[1]),
    .from_rpn_WNN_tvalid(src_valid[2]), .from_rpn_WNN_tready(src_ready[2]),
    .from_rpn_WNN_tdata(src_data[2]), .from_rpn_WNN_tkeep(src_keep[2]),
    .from_rpn_WNN_tid(src_id[2]), .from_rpn_WNN_tdest(src_dest[2]),
    .from_rpn_WNN_tuser(src_user[2]), .from_rpn_WNN_tlast(src_last[2]),
    .from_rpn_KIP_tvalid(src_valid[3]), .from_rpn_KIP_tready(src_ready[3]),
    .from_rpn_KIP_tdata(src_data[3]), .from_rpn_KIP_tkeep(src_keep[3]),
    .from_rpn_KIP_tid(src_id[3]), .from_rpn_KIP_tdest(src_dest[3]),
    .from_rpn_KIP_tuser(src_user[3]), .from_rpn_KIP_tlast(src_last[3]),
    .to_network_bridge_tvalid(nb_tvalid), .to_network_bridge_tready(nb_tready),
    .to_network_bridge_tdata(nb_tdata), .to_network_bridge_tkeep(nb_tkeep),
    .to_network_bridge_tid(nb_tid), .to_network_bridge_tdest(nb_tdest),
    .to_network_bridge_tuser(nb_tuser), .to_network_bridge_tlast(nb_tlast),
    .o_busy(o_busy), .o_grant(o_grant), .o_pkt_count(o_pkt_count)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, expv);
    end
  endtask

  // Queue a packet on a source; optionally record its beats as the next expected output.
  task automatic pkt(input int s, input int n, input logic [31:0] base, input bit push_exp);
    for (int b = 0; b < n; b++) begin
      src_q[s].push_back({(b == n - 1), 32'(base + 32'(b))});
      if (push_exp) exp_q.push_back('{src: 2'(s), data: 32'(base + 32'(b)), last: (b == n - 1)});
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d beats outstanding required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic flush_sources();
    for (int i = 0; i < 4; i++) src_q[i].delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush_sources();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // AXIS source models: hold each beat until a handshake is seen, then advance.
  initial begin
    bit hs [4];
    logic [31:0] d;
    for (int i = 0; i < 4; i++) begin
      src_valid[i] = 1'b0; src_data[i] = '0; src_keep[i] = '0; src_id[i] = '0;
      src_dest[i] = '0; src_user[i] = '0; src_last[i] = 1'b0; hs[i] = 1'b0;
    end
    nb_tready = 1'b1;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) hs[i] = rst_n && src_valid[i] && src_ready[i];
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (src_q[i].size() > 0) begin
          d            = src_q[i][0][31:0];
          src_valid[i] = 1'b1;
          src_last[i]  = src_q[i][0][32];
          src_data[i]  = DW'(d);
          src_keep[i]  = {d, d};
          src_id[i]    = TW'(i);
          src_dest[i]  = TW'(i + 8);
          src_user[i]  = d[15:0] ^ 16'hBEEF;
        end else begin
          src_valid[i] = 1'b0;
          src_last[i]  = 1'b0;
        end
      end
      nb_tready = toggle ? ~nb_tready : 1'b1;
    end
  end

  // Scoreboard monitor: every output handshake pops one expected beat.
  always @(negedge clk) begin
    if (rst_n) begin
      if (src_ready[0]) lan_ready_cnt++;
      for (int i = 0; i < 4; i++) begin
        if (!o_busy || 2'(i) != o_grant) chk("stray_tready", DW'(src_ready[i]), '0);
      end
      if (nb_tvalid && nb_tready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_beat: got tdata %0h required no beat", nb_tdata);
        end else begin
          exp_t e;
          logic [31:0] d;
          e = exp_q.pop_front();
          d = e.data;
          hs_cyc.push_back(cyc);
          chk("tdata", nb_tdata, DW'(d));
          chk("tlast", DW'(nb_tlast), DW'(e.last));
          chk("tkeep", DW'(nb_tkeep), DW'({d, d}));
          chk("tid", DW'(nb_tid), DW'(e.src));
          chk("tdest", DW'(nb_tdest), DW'(e.src) + 8);
          chk("tuser", DW'(nb_tuser), DW'(d[15:0] ^ 16'hBEEF));
`ifndef RPN_TO_NB_MERGER_OUTPUT_REG_EN
          chk("grant", DW'(o_grant), DW'(e.src));
`endif
        end
      end else if (nb_tvalid && exp_q.size() > 0) begin
        chk("held_tdata", nb_tdata, DW'(exp_q[0].data));
      end
    end
  end

  initial begin
    int start;
    #1;
    chk("rst_tvalid", DW'(nb_tvalid), '0);
    chk("rst_busy", DW'(o_busy), '0);
    chk("rst_grant", DW'(o_grant), '0);
    chk("rst_pkt_count", DW'(o_pkt_count), '0);
    chk("rst_tdata", nb_tdata, '0);
    chk("rst_lan_tready", DW'(src_ready[0]), '0);
    do_reset();

    // single-beat LAN packet
    @(posedge clk); #2;
    start = cyc; hs_cyc.delete(); lan_ready_cnt = 0;
    pkt(0, 1, 32'hA5, 1);
    wait_drain(20);
    if (hs_cyc.size() > 0) chk("t1_latency", DW'(hs_cyc[0]), DW'(start + 1 + LAT));
    @(posedge clk); #1;
    chk("t1_lan_ready_cycles", DW'(lan_ready_cnt), DW'(1));
    chk("t1_pkt_count", DW'(o_pkt_count), DW'(1));

    // all four sources contend from reset with 3-beat packets
    do_reset();
    @(posedge clk); #2;
    start = cyc; hs_cyc.delete();
    pkt(0, 3, 32'h1000, 1);
    pkt(1, 3, 32'h2000, 1);
    pkt(2, 3, 32'h3000, 1);
    pkt(3, 3, 32'h4000, 1);
    wait_drain(60);
    chk("t2_beats", DW'(hs_cyc.size()), DW'(12));
    for (int i = 0; i < 12 && i < hs_cyc.size(); i++)
      chk("t2_beat_cycle", DW'(hs_cyc[i]), DW'(start + 1 + LAT + 4 * (i / 3) + (i % 3)));
    @(posedge clk); #1;
    chk("t2_pkt_count", DW'(o_pkt_count), DW'(4));

    // LAN and KIP keep offering 1-beat packets: grant must alternate
    for (int k = 0; k < 3; k++) begin
      pkt(0, 1, 32'h5100 + 32'(k), 1);
      pkt(3, 1, 32'h5300 + 32'(k), 1);
    end
    wait_drain(60);
    @(posedge clk); #1;
    chk("t4_pkt_count", DW'(o_pkt_count), DW'(10));

    // WAN 4-beat packet under alternating backpressure
    toggle = 1'b1;
    pkt(1, 4, 32'h6000, 1);
    wait_drain(60);
    toggle = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("t3_pkt_count", DW'(o_pkt_count), DW'(11));

    // reset during beat 2 of a 5-beat WNN packet
    pkt(2, 5, 32'h7000, 0);
    exp_q.push_back('{src: 2'd2, data: 32'h7000, last: 1'b0});
    exp_q.push_back('{src: 2'd2, data: 32'h7001, last: 1'b0});
    wait_drain(40);
    rst_n = 1'b0;
    flush_sources();
    #1;
    chk("mid_rst_tvalid", DW'(nb_tvalid), '0);
    chk("mid_rst_tdata", nb_tdata, '0);
    chk("mid_rst_busy", DW'(o_busy), '0);
    chk("mid_rst_pkt_count", DW'(o_pkt_count), '0);
    chk("mid_rst_wnn_tready", DW'(src_ready[2]), '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_busy", DW'(o_busy), '0);
    chk("post_rst_pkt_count", DW'(o_pkt_count), '0);
    @(posedge clk); #2;
    pkt(3, 1, 32'h8300, 0);
    pkt(2, 1, 32'h8200, 0);
    pkt(1, 1, 32'h8100, 0);
    pkt(0, 1, 32'h8000, 0);
    for (int s = 0; s < 4; s++) exp_q.push_back('{src: 2'(s), data: 32'h8000 + 32'(s) * 32'h100, last: 1'b1});
    wait_drain(40);
    @(posedge clk); #1;
    chk("t5_pkt_count", DW'(o_pkt_count), DW'(4));

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running required finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "timeout");
  end

endmodule
